// File: rtl/rs_flipflop_bank.sv
// Bank of WIDTH clocked RS flip-flops with selectable S=R=1 resolution, edge pulses and conflict tracking.
// Q and all flags update on the edge that samples S/R; no flow control, en simply freezes the bank.
module rs_flipflop_bank #(
    parameter int                   WIDTH     = 8,
    parameter int                   MODE      = 0,
    parameter logic [WIDTH-1:0]     INIT      = {WIDTH{1'b0}},
    parameter int                   CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [WIDTH-1:0]        S,
    input  logic [WIDTH-1:0]        R,
    input  logic                    clrErr,
    output logic [WIDTH-1:0]        Q,
    output logic [WIDTH-1:0]        notQ,
    output logic [WIDTH-1:0]        qRise,
    output logic [WIDTH-1:0]        qFall,
    output logic [WIDTH-1:0]        conflict,
    output logic [CNT_WIDTH-1:0]    conflictCount,
    output logic                    errSticky
);

    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_rise;
    logic [WIDTH-1:0]     r_fall;
    logic [WIDTH-1:0]     r_conf;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_err;

    logic [WIDTH-1:0]     w_both_val;
    logic [WIDTH-1:0]     w_next;
    logic [WIDTH-1:0]     w_conf;
    logic                 w_any_conf;

    // Value a bit takes when S and R are both asserted.
    generate
        if (MODE == 0) begin : g_reset_dom
            assign w_both_val = {WIDTH{1'b0}};
        end else if (MODE == 1) begin : g_set_dom
            assign w_both_val = {WIDTH{1'b1}};
        end else if (MODE == 2) begin : g_hold
            assign w_both_val = r_q;
        end else if (MODE == 3) begin : g_toggle
            assign w_both_val = ~r_q;
        end else begin : g_bad_mode
            $error("rs_flipflop_bank: MODE must be 0..3");
        end
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("rs_flipflop_bank: WIDTH must be 1..64");
        end
    endgenerate

    assign w_next     = (r_q & ~S & ~R) | (S & ~R) | (S & R & w_both_val);
    assign w_conf     = S & R & {WIDTH{en}};
    assign w_any_conf = |w_conf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= INIT;
            r_rise <= '0;
            r_fall <= '0;
            r_conf <= '0;
        end else begin
            r_conf <= w_conf;
            if (en) begin
                r_q    <= w_next;
                r_rise <= w_next & ~r_q;
                r_fall <= ~w_next & r_q;
            end else begin
                r_rise <= '0;
                r_fall <= '0;
            end
        end
    end

    // clrErr wins over a same-edge conflict; the per-bit conflict flag above still reports it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (clrErr) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_any_conf) begin
            r_err <= 1'b1;
            if (r_cnt != {CNT_WIDTH{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign Q             = r_q;
    assign notQ          = ~r_q;
    assign qRise         = r_rise;
    assign qFall         = r_fall;
    assign conflict      = r_conf;
    assign conflictCount = r_cnt;
    assign errSticky     = r_err;

endmodule

// File: tb/tb_rs_flipflop_bank.sv
// Drives four MODE variants (INIT=A5, 4-bit counter) and one default-parameter instance in parallel.
module tb_rs_flipflop_bank;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic [7:0] s;
    logic [7:0] r;

    logic [7:0] q    [N];
    logic [7:0] nq   [N];
    logic [7:0] rise [N];
    logic [7:0] fall [N];
    logic [7:0] conf [N];
    logic       err  [N];
    logic [3:0] cnt4 [4];
    logic [7:0] cnt_def;

    int         mode_of [N] = '{0, 1, 2, 3, 0};
    logic [7:0] init_of [N] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    int         cmax    [N] = '{15, 15, 15, 15, 255};

    logic [7:0] m_q    [N];
    logic [7:0] m_rise [N];
    logic [7:0] m_fall [N];
    logic [7:0] m_conf [N];
    int         m_cnt  [N];
    logic       m_err  [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        rs_flipflop_bank #(.WIDTH(8), .MODE(m), .INIT(8'hA5), .CNT_WIDTH(4)) u_dut (
            .clk(clk), .rst(rst), .en(en), .S(s), .R(r), .clrErr(clr),
            .Q(q[m]), .notQ(nq[m]), .qRise(rise[m]), .qFall(fall[m]),
            .conflict(conf[m]), .conflictCount(cnt4[m]), .errSticky(err[m])
        );
    end

    rs_flipflop_bank u_dut_def (
        .clk(clk), .rst(rst), .en(en), .S(s), .R(r), .clrErr(clr),
        .Q(q[4]), .notQ(nq[4]), .qRise(rise[4]), .qFall(fall[4]),
        .conflict(conf[4]), .conflictCount(cnt_def), .errSticky(err[4])
    );

    function automatic int cnt_of(input int i);
        if (i < 4) return int'(cnt4[i]);
        return int'(cnt_def);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_q[i] = init_of[i]; m_rise[i] = '0; m_fall[i] = '0;
            m_conf[i] = '0; m_cnt[i] = 0; m_err[i] = 1'b0;
        end
    endtask

    // Reference: apply the truth table per bit, then derive flags and counter from old/new state.
    task automatic model_edge(input logic [7:0] sv, input logic [7:0] rv, input logic ev, input logic cv);
        logic [7:0] nx;
        for (int i = 0; i < N; i++) begin
            nx = m_q[i];
            if (ev) begin
                for (int b = 0; b < 8; b++) begin
                    if (sv[b] && !rv[b]) nx[b] = 1'b1;
                    else if (!sv[b] && rv[b]) nx[b] = 1'b0;
                    else if (sv[b] && rv[b]) begin
                        case (mode_of[i])
                            0: nx[b] = 1'b0;
                            1: nx[b] = 1'b1;
                            3: nx[b] = ~m_q[i][b];
                            default: nx[b] = m_q[i][b];
                        endcase
                    end
                end
            end
            m_rise[i] = nx & ~m_q[i];
            m_fall[i] = ~nx & m_q[i];
            m_conf[i] = ev ? (sv & rv) : 8'h00;
            if (cv) begin
                m_cnt[i] = 0; m_err[i] = 1'b0;
            end else if (m_conf[i] != 8'h00) begin
                if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
                m_err[i] = 1'b1;
            end
            m_q[i] = nx;
        end
    endtask

    task automatic cycle(input logic [7:0] sv, input logic [7:0] rv, input logic ev, input logic cv);
        s = sv; r = rv; en = ev; clr = cv;
        @(posedge clk);
        model_edge(sv, rv, ev, cv);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; s = '0; r = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (q[i] !== init_of[i] || nq[i] !== ~init_of[i]) begin
                n_fail++; $display("FAIL reset_q[%0d]: Q=%h notQ=%h, want %h/%h", i, q[i], nq[i], init_of[i], ~init_of[i]);
            end
            n_checks++;
            if (rise[i] !== 8'h00 || fall[i] !== 8'h00 || conf[i] !== 8'h00 || cnt_of(i) != 0 || err[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_flags[%0d]: rise=%h fall=%h conf=%h cnt=%0d err=%b, want all 0", i, rise[i], fall[i], conf[i], cnt_of(i), err[i]);
            end
        end
        rst = 1'b0;
        cycle(8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (q[i] !== init_of[i]) begin
                n_fail++; $display("FAIL reset_release[%0d]: Q=%h want %h", i, q[i], init_of[i]);
            end
        end
    endtask

    task automatic test_set_clear();
        cycle(8'h00, 8'hFF, 1'b1, 1'b0);
        cycle(8'h0F, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (q[i] !== 8'h0F || rise[i] !== 8'h0F || fall[i] !== 8'h00) begin
                n_fail++; $display("FAIL set[%0d]: Q=%h rise=%h fall=%h, want 0F/0F/00", i, q[i], rise[i], fall[i]);
            end
        end
        cycle(8'h00, 8'h03, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (q[i] !== 8'h0C || rise[i] !== 8'h00 || fall[i] !== 8'h03 || conf[i] !== 8'h00 || cnt_of(i) != 0) begin
                n_fail++; $display("FAIL clear[%0d]: Q=%h rise=%h fall=%h conf=%h cnt=%0d, want 0C/00/03/00/0", i, q[i], rise[i], fall[i], conf[i], cnt_of(i));
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0] exp_q [N];
        logic [7:0] exp_f [N];
        exp_q = '{8'h0C, 8'h0D, 8'h0D, 8'h0C, 8'h0C};
        exp_f = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
        cycle(8'h01, 8'h00, 1'b1, 1'b0);
        cycle(8'h01, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (q[i] !== exp_q[i] || rise[i] !== 8'h00 || fall[i] !== exp_f[i]) begin
                n_fail++; $display("FAIL mode_q[%0d]: Q=%h rise=%h fall=%h, want %h/00/%h", i, q[i], rise[i], fall[i], exp_q[i], exp_f[i]);
            end
            n_checks++;
            if (conf[i] !== 8'h01 || cnt_of(i) != 1 || err[i] !== 1'b1) begin
                n_fail++; $display("FAIL mode_conf[%0d]: conf=%h cnt=%0d err=%b, want 01/1/1", i, conf[i], cnt_of(i), err[i]);
            end
        end
        cycle(8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (cnt_of(i) != 0 || err[i] !== 1'b0 || conf[i] !== 8'h00 || q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL mode_clr[%0d]: cnt=%0d err=%b conf=%h Q=%h, want 0/0/00/%h", i, cnt_of(i), err[i], conf[i], q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_enable();
        logic [7:0] saved [N];
        for (int i = 0; i < N; i++) saved[i] = q[i];
        cycle(8'hFF, 8'h00, 1'b0, 1'b0);
        cycle(8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (q[i] !== saved[i] || rise[i] !== 8'h00 || fall[i] !== 8'h00 || conf[i] !== 8'h00 || cnt_of(i) != 0 || err[i] !== 1'b0) begin
                n_fail++; $display("FAIL enable_off[%0d]: Q=%h rise=%h conf=%h cnt=%0d err=%b, want Q=%h rest 0", i, q[i], rise[i], conf[i], cnt_of(i), err[i], saved[i]);
            end
        end
        cycle(8'h01, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cycle(8'h01, 8'h01, 1'b1, 1'b0);
            n_checks++;
            if (q[3][0] !== (k % 2 == 0) || q[2][0] !== 1'b1) begin
                n_fail++; $display("FAIL toggle edge %0d: mode3 Q0=%b mode2 Q0=%b, want %b/1", k, q[3][0], q[2][0], (k % 2 == 0));
            end
        end
        cycle(8'h00, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        cycle(8'hFF, 8'h00, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (q[i] !== init_of[i] || nq[i] !== ~init_of[i]) begin
                n_fail++; $display("FAIL async_rst[%0d]: Q=%h notQ=%h, want %h/%h", i, q[i], nq[i], init_of[i], ~init_of[i]);
            end
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_saturate();
        for (int k = 1; k <= 20; k++) begin
            cycle(8'h01, 8'h01, 1'b1, 1'b0);
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (cnt_of(i) != ((i < 4 && k > 15) ? 15 : k) || err[i] !== 1'b1) begin
                    n_fail++; $display("FAIL sat[%0d] edge %0d: cnt=%0d err=%b, want %0d/1", i, k, cnt_of(i), err[i], (i < 4 && k > 15) ? 15 : k);
                end
            end
        end
        cycle(8'h01, 8'h01, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (cnt_of(i) != 0 || err[i] !== 1'b0 || conf[i] !== 8'h01) begin
                n_fail++; $display("FAIL clr_with_conf[%0d]: cnt=%0d err=%b conf=%h, want 0/0/01", i, cnt_of(i), err[i], conf[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] sv, rv;
        logic       ev, cv;
        for (int c = 0; c < 10000; c++) begin
            sv = 8'($urandom);
            rv = ($urandom_range(0, 1) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom) & 8'($urandom));
            ev = ($urandom_range(0, 3) != 0);
            cv = ($urandom_range(0, 40) == 0);
            cycle(sv, rv, ev, cv);
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (q[i] !== m_q[i] || nq[i] !== ~m_q[i]) begin
                    n_fail++; $display("FAIL rand_q[%0d] cyc %0d: Q=%h notQ=%h, want %h/%h", i, c, q[i], nq[i], m_q[i], ~m_q[i]);
                end
                n_checks++;
                if (rise[i] !== m_rise[i] || fall[i] !== m_fall[i]) begin
                    n_fail++; $display("FAIL rand_edge[%0d] cyc %0d: rise=%h fall=%h, want %h/%h", i, c, rise[i], fall[i], m_rise[i], m_fall[i]);
                end
                n_checks++;
                if (conf[i] !== m_conf[i] || cnt_of(i) != m_cnt[i] || err[i] !== m_err[i]) begin
                    n_fail++; $display("FAIL rand_conf[%0d] cyc %0d: conf=%h cnt=%0d err=%b, want %h/%0d/%b", i, c, conf[i], cnt_of(i), err[i], m_conf[i], m_cnt[i], m_err[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_modes();
        test_enable();
        test_async_reset();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
